mult_arbiter: RTL and testbench

Round-robin front end that shares one sequential 8x8 multiplier (start/done core driven by `mult_control`) between `N_REQ` requesters. It accepts one operand pair per transaction, issues a single-cycle start to the core, waits for done, and returns the 16-bit product tagged with the requester index over a valid/ready response channel. It sits between client logic and the multiplier top level and is the only block that drives the core's start and operand inputs.

---
 rtl/mult_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/mult_arbiter.sv | 150 +++++++++++++++
 tb/tb_mult_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants for the multiplier arbiter: FSM encoding, datapath widths,
// and the operand-pair payload type.
package mult_arb_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester at or above ptr
// (wrapping upward) wins.
//   req   - request vector
//   ptr   - search start index (< N_REQ)
//   grant - one-hot grant, all zero when no request
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    int idx;
    logic [N_REQ-1:0] cand;
    grant = '0;
    for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
      idx  = (int'(ptr) + off) % int'(N_REQ);
      cand = N_REQ'(1) << idx;
      if (|(req & cand)) grant = cand;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one start/done 8x8 multiplier core among
// N_REQ requesters; returns the tagged product on a valid/ready channel.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT
// cycles with rsp_err=1 and a zero product.
// Ports:
//   clk, reset_a            - clock, async active-low reset
//   req_valid/req_a/req_b   - per-requester request and packed operands
//   req_ready               - one-hot accept strobe (combinational)
//   rsp_valid/rsp_ready     - response handshake
//   rsp_id/rsp_product/rsp_err - response payload
//   mult_start/mult_dataa/mult_datab - core command
//   mult_done/mult_product  - core completion
//   state_out               - FSM state for debug
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_a,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    rsp_err,
  output logic                    mult_start,
  output logic [OP_W-1:0]         mult_dataa,
  output logic [OP_W-1:0]         mult_datab,
  input  logic                    mult_done,
  input  logic [PROD_W-1:0]       mult_product,
  output logic [1:0]              state_out
);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_next, gnt_idx;
  logic [N_REQ-1:0] grant;
  operands_t        sel_ops;
  logic             accept, load_rsp, err_d, expired;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign state_out = state_q;

  // Encode the grant and steer the winner's operands.
  always_comb begin
    gnt_idx = '0;
    sel_ops = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx   = ID_W'(i);
        sel_ops.a = req_a[i*OP_W +: OP_W];
        sel_ops.b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

`ifdef MULT_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Cleared while in ISSUE so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a)                wait_cnt <= '0;
    else if (state_q == ST_ISSUE) wait_cnt <= '0;
    else if (state_q == ST_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign expired = (wait_cnt == CNT_W'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = ^CNT_W'(TIMEOUT);
  assign expired        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and transaction strobes; done takes priority over expiry.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_rsp = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mult_done) begin
          load_rsp = 1'b1;
          state_d  = ST_RESP;
        end else if (expired) begin
          load_rsp = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and pointer.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      ptr_q       <= '0;
      mult_start  <= 1'b0;
      mult_dataa  <= '0;
      mult_datab  <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      mult_start <= accept;
      rsp_valid  <= (state_d == ST_RESP);
      if (accept) begin
        mult_dataa <= sel_ops.a;
        mult_datab <= sel_ops.b;
        rsp_id     <= gnt_idx;
        ptr_q      <= ptr_next;
      end
      if (load_rsp) begin
        rsp_product <= err_d ? '0 : mult_product;
        rsp_err     <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             reset_a;
  logic [N-1:0]     req_valid, req_ready;
  logic [8*N-1:0]   req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [1:0]       rsp_id, state_out;
  logic [15:0]      rsp_product, mult_product;
  logic             mult_start, mult_done;
  logic [7:0]       mult_dataa, mult_datab;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset_a(reset_a),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mult_start(mult_start), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_done(mult_done), .mult_product(mult_product), .state_out(state_out)
  );

  // Behavioural multiplier core: done pulses core_lat cycles after the start edge.
  logic        core_mute;
  int          core_lat;
  logic        core_busy, core_done;
  int          core_cnt;
  logic [15:0] core_prod;

  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      core_busy <= 1'b0; core_done <= 1'b0; core_cnt <= 0; core_prod <= '0;
    end else begin
      core_done <= 1'b0;
      if (mult_start) begin
        core_prod <= 16'(mult_dataa) * 16'(mult_datab);
        if (core_lat == 0) begin
          core_done <= !core_mute; core_busy <= 1'b0;
        end else begin
          core_cnt <= core_lat - 1; core_busy <= 1'b1;
        end
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_done <= !core_mute; core_busy <= 1'b0;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end

  assign mult_done    = core_done;
  assign mult_product = core_done ? core_prod : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_a = 1'b0; req_valid = '0; rsp_ready = 1'b0; core_mute = 1'b0;
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
  endtask

  // Bounded wait for rsp_valid; returns the number of negedges waited.
  task automatic wait_rsp(input string nm, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(rsp_valid === 1'b1), 32'd1);
  endtask

  // One isolated transaction with full timing checks.
  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat);
    int n;
    core_lat = lat;
    @(negedge clk);
    req_a = 24'($urandom); req_b = 24'($urandom);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid = oh(id);
    rsp_ready = 1'b1;
    #1 chk("accept_ready", 32'(req_ready), 32'(oh(id)));
    @(negedge clk);
    req_valid = '0;
    chk("start_at_T1", 32'(mult_start), 32'd1);
    chk("ready_in_issue", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("start_one_cycle", 32'(mult_start), 32'd0);
    chk("wait_at_T2", 32'(state_out), 32'd2);
    wait_rsp("rsp_arrives", n);
    chk("rsp_latency", 32'(n + 1), 32'(lat + 2));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_product", 32'(rsp_product), 32'(exp));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk("rsp_consumed", 32'(rsp_valid), 32'd0);
    chk("back_idle", 32'(state_out), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int n;
    logic [15:0] held_prod;
    logic [1:0]  held_id;
    // random-model state
    logic [N-1:0] pend, exp_ready;
    logic [7:0]   opa[N], opb[N];
    int           p, g, exp_id, busy_cycles;
    logic [15:0]  exp_prod;
    bit           busy, exp_valid, hs_sched, done_seen, start_due;

    vecs[0] = '{0, 8'd25,  8'd10,  16'd250,   2};
    vecs[1] = '{0, 8'd0,   8'd200, 16'd0,     0};
    vecs[2] = '{1, 8'd255, 8'd255, 16'hFE01,  1};
    vecs[3] = '{2, 8'd3,   8'd7,   16'd21,    3};
    vecs[4] = '{1, 8'd128, 8'd2,   16'd256,   0};
    vecs[5] = '{2, 8'd200, 8'd0,   16'd0,     4};
    vecs[6] = '{0, 8'd17,  8'd15,  16'd255,   1};

    reset_a = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; core_mute = 1'b0; core_lat = 1;

    do_reset();
    @(negedge clk);
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_start", 32'(mult_start), 32'd0);
    chk("reset_product", 32'(rsp_product), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++)
      run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Contention: req0 (255,255) and req1 (3,7) held continuously.
    do_reset();
    core_lat = 1;
    @(negedge clk);
    req_a = {8'd0, 8'd3, 8'd255};
    req_b = {8'd0, 8'd7, 8'd255};
    req_valid = 3'b011;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("contend_rsp", n);
      chk("contend_id", 32'(rsp_id), 32'(k % 2));
      chk("contend_prod", 32'(rsp_product), (k % 2) ? 32'd21 : 32'hFE01);
      @(negedge clk);
    end

    // Response stall: pointer is at 2, so req0 wins next.
    rsp_ready = 1'b0;
    wait_rsp("stall_rsp", n);
    held_prod = rsp_product;
    held_id   = rsp_id;
    chk("stall_id", 32'(held_id), 32'd0);
    chk("stall_prod", 32'(held_prod), 32'hFE01);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_prod_stable", 32'(rsp_product), 32'(held_prod));
      chk("stall_id_stable", 32'(rsp_id), 32'(held_id));
      chk("stall_no_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_release_idle", 32'(state_out), 32'd0);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_no_accept", 32'(state_out), 32'd0);

    // Reset during WAIT; req1 moves the pointer to 2 before the reset.
    core_mute = 1'b1;
    core_lat  = 0;
    @(negedge clk);
    req_a = {8'd0, 8'd9, 8'd0};
    req_b = {8'd0, 8'd11, 8'd0};
    req_valid = 3'b010;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (state_out !== 2'd2 && n < 20) begin @(negedge clk); n++; end
    chk("reach_wait", 32'(state_out), 32'd2);
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_dataa", 32'(mult_dataa), 32'd0);
    chk("rst_datab", 32'(mult_datab), 32'd0);
    chk("rst_start", 32'(mult_start), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    core_mute = 1'b0;
    core_lat = 1;
    @(negedge clk);
    req_a = {8'd5, 8'd6, 8'd0};
    req_b = {8'd5, 8'd7, 8'd0};
    req_valid = 3'b110;
    rsp_ready = 1'b1;
    #1 chk("rst_ptr_grant", 32'(req_ready), 32'b010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("rst_rsp", n);
    chk("rst_after_id", 32'(rsp_id), 32'd1);
    chk("rst_after_prod", 32'(rsp_product), 32'd42);
    @(negedge clk);

    // Stuck core.
    core_mute = 1'b1;
    @(negedge clk);
    req_a = {8'd0, 8'd0, 8'd9};
    req_b = {8'd0, 8'd0, 8'd9};
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (state_out !== 2'd2 && n < 20) begin @(negedge clk); n++; end
    chk("to_reach_wait", 32'(state_out), 32'd2);
`ifdef MULT_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("timeout_cycles", 32'(n), 32'd17);
    chk("timeout_err", 32'(rsp_err), 32'd1);
    chk("timeout_prod", 32'(rsp_product), 32'd0);
    @(negedge clk);
    chk("timeout_consumed", 32'(state_out), 32'd0);
`else
    repeat (100) @(negedge clk);
    chk("no_timeout_state", 32'(state_out), 32'd2);
    chk("no_timeout_valid", 32'(rsp_valid), 32'd0);
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    pend = '0; p = 0; busy = 0; exp_valid = 0; hs_sched = 0;
    done_seen = 0; start_due = 0; exp_id = 0; exp_prod = '0; busy_cycles = 0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (hs_sched) begin exp_valid = 0; busy = 0; hs_sched = 0; end
      if (done_seen) begin exp_valid = 1; done_seen = 0; end
      chk("rnd_start", 32'(mult_start), 32'(start_due));
      start_due = 0;
      chk("rnd_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_id", 32'(rsp_id), 32'(exp_id));
        chk("rnd_prod", 32'(rsp_product), 32'(exp_prod));
        chk("rnd_err", 32'(rsp_err), 32'd0);
      end
      if (mult_done === 1'b1) done_seen = 1;
      busy_cycles = busy ? busy_cycles + 1 : 0;
      if (busy_cycles > 150) begin
        chk("rnd_progress", 32'd0, 32'd1);
        break;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = 8'($urandom);
          opb[i]  = 8'($urandom);
        end
        req_a[i*8 +: 8] = pend[i] ? opa[i] : 8'($urandom);
        req_b[i*8 +: 8] = pend[i] ? opb[i] : 8'($urandom);
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (exp_valid && rsp_ready) hs_sched = 1;
      core_lat = $urandom_range(0, 4);
      #1;
      exp_ready = '0;
      if (!busy && pend != '0) begin
        g = rr_pick(pend, p);
        exp_ready = oh(g);
      end
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
        busy      = 1;
        start_due = 1;
        exp_id    = g;
        exp_prod  = 16'(opa[g]) * 16'(opb[g]);
        pend[g]   = 1'b0;
        p         = (g + 1) % N;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
